// File: rtl/pipeline_reg_wb_elastic.sv
// MEM/WB elastic pipeline register: head entry plus one skid entry behind a
// valid/ready handshake, with flush, x0 write suppression and a stall counter.
module pipeline_reg_wb_elastic #(
  parameter int DATA_W        = 32,
  parameter int IDX_W         = 5,
  parameter bit ZERO_SUPPRESS = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              reg_write_in,
  input  logic [IDX_W-1:0]  rd_idx_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              reg_write_out,
  output logic [IDX_W-1:0]  rd_idx_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a payload moves on a side when valid && ready at the rising
  // edge; in_ready comes from stored state only, never from out_ready.
  logic [DATA_W-1:0] head_data, skid_data;
  logic              head_we, skid_we;
  logic [IDX_W-1:0]  head_idx, skid_idx;
  logic              head_valid, skid_valid;
  logic              accept, consume;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign consume  = head_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_data  <= '0;
      head_we    <= 1'b0;
      head_idx   <= '0;
      head_valid <= 1'b0;
      skid_data  <= '0;
      skid_we    <= 1'b0;
      skid_idx   <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!head_valid || consume) begin
      // Head is free this cycle; the skid entry is older than any new input.
      if (skid_valid) begin
        head_data  <= skid_data;
        head_we    <= skid_we;
        head_idx   <= skid_idx;
        head_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        head_data  <= wb_data_in;
        head_we    <= reg_write_in;
        head_idx   <= rd_idx_in;
        head_valid <= 1'b1;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= wb_data_in;
      skid_we    <= reg_write_in;
      skid_idx   <= rd_idx_in;
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (head_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid     = head_valid;
  assign wb_data_out   = head_data;
  assign rd_idx_out    = head_idx;
  assign reg_write_out = head_valid && head_we &&
                         !(ZERO_SUPPRESS && (head_idx == '0));

endmodule

// File: tb/tb_pipeline_reg_wb_elastic.sv
// Bench for pipeline_reg_wb_elastic: directed steps then random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_pipeline_reg_wb_elastic;

  localparam int DW = 32;
  localparam int IW = 5;
  localparam int PW = DW + 1 + IW;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] wb_data_in;
  logic          reg_write_in;
  logic [IW-1:0] rd_idx_in;
  logic          out_ready;

  logic          in_ready, out_valid, reg_write_out;
  logic [DW-1:0] wb_data_out;
  logic [IW-1:0] rd_idx_out;
  logic [15:0]   stall_cnt;

  logic          in_ready_s, out_valid_s, reg_write_out_s;
  logic [DW-1:0] wb_data_out_s;
  logic [IW-1:0] rd_idx_out_s;
  logic [3:0]    stall_cnt_s;

  pipeline_reg_wb_elastic #(.DATA_W(DW), .IDX_W(IW), .ZERO_SUPPRESS(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_data_in(wb_data_in), .reg_write_in(reg_write_in), .rd_idx_in(rd_idx_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data_out(wb_data_out), .reg_write_out(reg_write_out), .rd_idx_out(rd_idx_out),
    .stall_cnt(stall_cnt)
  );

  pipeline_reg_wb_elastic #(.DATA_W(DW), .IDX_W(IW), .ZERO_SUPPRESS(1'b1), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .wb_data_in(wb_data_in), .reg_write_in(reg_write_in), .rd_idx_in(rd_idx_in),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .wb_data_out(wb_data_out_s), .reg_write_out(reg_write_out_s), .rd_idx_out(rd_idx_out_s),
    .stall_cnt(stall_cnt_s)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: FIFO of at most two payloads {data, we, idx}
  logic [PW-1:0] exp_q[$];
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_idx;
  int            m_cnt, m_cnt_s;
  int            tests, fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [PW-1:0] p;
    int sz;
    sz = exp_q.size();
    if (!reset) begin
      exp_q.delete();
      m_data  = '0;
      m_idx   = '0;
      m_cnt   = 0;
      m_cnt_s = 0;
    end else begin
      if (sz > 0 && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (sz > 0 && out_ready) exp_q.delete(0);
        if (in_valid && sz < 2) exp_q.push_back({wb_data_in, reg_write_in, rd_idx_in});
        if (exp_q.size() > 0) begin
          p      = exp_q[0];
          m_data = p[PW-1 -: DW];
          m_idx  = p[IW-1:0];
        end
      end
    end
  endtask

  task automatic check_all();
    logic [PW-1:0] p;
    logic exp_we;
    int sz;
    sz = exp_q.size();
    exp_we = 1'b0;
    if (sz > 0) begin
      p = exp_q[0];
      exp_we = p[IW] && (p[IW-1:0] != '0);
    end
    check("in_ready",      32'(in_ready),      32'(sz < 2));
    check("out_valid",     32'(out_valid),     32'(sz > 0));
    check("wb_data_out",   wb_data_out,        m_data);
    check("rd_idx_out",    32'(rd_idx_out),    32'(m_idx));
    check("reg_write_out", 32'(reg_write_out), 32'(exp_we));
    check("stall_cnt",     32'(stall_cnt),     32'(m_cnt));
    check("out_valid_s",   32'(out_valid_s),   32'(sz > 0));
    check("stall_cnt_s",   32'(stall_cnt_s),   32'(m_cnt_s));
  endtask

  // driver tasks: inputs are stable before the edge, outputs sampled 1 ns after
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic we, input logic [IW-1:0] idx);
    in_valid     = 1'b1;
    wb_data_in   = d;
    reg_write_in = we;
    rd_idx_in    = idx;
    cycle();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cycle();
  endtask

  int saved_cnt;

  initial begin
    tests = 0;
    fails = 0;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    wb_data_in = 32'hDEAD_BEEF;
    reg_write_in = 1'b1;
    rd_idx_in = 5'd9;

    // reset with a payload offered
    reset = 1'b0;
    cycle();
    cycle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_data",      wb_data_out,    32'd0);
    check("rst_stall",     32'(stall_cnt), 32'd0);
    reset = 1'b1;
    idle();

    // streaming at full rate
    send(32'h11, 1'b1, 5'd3);
    check("stream_lat", wb_data_out, 32'h11);
    send(32'h22, 1'b1, 5'd4);
    check("stream_2", wb_data_out, 32'h22);
    send(32'h33, 1'b1, 5'd5);
    check("stream_3", 32'(rd_idx_out), 32'd5);
    idle();
    check("stream_drain", 32'(out_valid), 32'd0);

    // backpressure fills the skid entry
    out_ready = 1'b0;
    send(32'hAAAA, 1'b1, 5'd1);
    send(32'hBBBB, 1'b1, 5'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    idle();
    idle();
    idle();
    check("bp_stall4", 32'(stall_cnt), 32'd4);
    check("bp_head_a", wb_data_out, 32'hAAAA);
    out_ready = 1'b1;
    idle();
    check("bp_head_b", wb_data_out, 32'hBBBB);
    idle();
    check("bp_empty", 32'(out_valid), 32'd0);

    // flush with both entries held and C offered
    out_ready = 1'b0;
    send(32'hAAAA, 1'b1, 5'd1);
    send(32'hBBBB, 1'b1, 5'd2);
    saved_cnt = m_cnt;
    out_ready = 1'b1;
    flush = 1'b1;
    send(32'hCCCC, 1'b1, 5'd6);
    flush = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready",  32'(in_ready),  32'd1);
    check("fl_stall",     32'(stall_cnt), 32'(saved_cnt));
    idle();
    check("fl_no_c", 32'(out_valid), 32'd0);

    // write to x0 suppressed, same payload to x7 enabled
    out_ready = 1'b0;
    send(32'h5, 1'b1, 5'd0);
    check("zs_valid", 32'(out_valid),     32'd1);
    check("zs_x0",    32'(reg_write_out), 32'd0);
    out_ready = 1'b1;
    send(32'h5, 1'b1, 5'd7);
    check("zs_x7",    32'(reg_write_out), 32'd1);
    idle();

    // long stall saturates the 4-bit counter
    out_ready = 1'b0;
    send(32'h77, 1'b0, 5'd8);
    for (int i = 0; i < 20; i++) idle();
    check("sat_15", 32'(stall_cnt_s), 32'd15);
    idle();
    check("sat_hold", 32'(stall_cnt_s), 32'd15);
    out_ready = 1'b1;
    idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 99) != 0);
      flush        = ($urandom_range(0, 99) < 3);
      out_ready    = ($urandom_range(0, 99) < 65);
      in_valid     = ($urandom_range(0, 99) < 60);
      wb_data_in   = $urandom;
      reg_write_in = $urandom_range(0, 1);
      rd_idx_in    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
